pool_stream_ctrl: RTL and testbench

- Sequencer that streams one IN_H×IN_W feature map (one OUT_CH vector per address) from the activation buffer into the 2×2/stride-2 maxpool stage.
- Issues buffer reads in raster order and drives the pool stage's in_valid aligned to the buffer read latency.
- After each row pair it pauses feeding until the pool stage has emitted that pair's IN_W/2 pooled vectors, then resumes.
- Sits between the layer scheduler (start/done) and the buffer + maxpool datapath.

---
 rtl/pool_stream_ctrl.sv | 155 +++++++++++++++
 tb/tb_pool_stream_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_stream_ctrl.sv
// rtl/pool_stream_ctrl.sv - raster-order read sequencer feeding a 2x2/stride-2 maxpool stage
// Defining POOL_WDOG_EN adds a WAIT_POOL watchdog that sets the sticky err flag.
module pool_stream_ctrl #(
    parameter int IN_W     = 28,
    parameter int IN_H     = 28,
    parameter int ADDR_W   = 10,
    parameter int RD_LAT   = 1,
    parameter int WDOG_CYC = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [ADDR_W-1:0]                   base_addr,
    input  logic                                hold,
    output logic                                rd_en,
    output logic [ADDR_W-1:0]                   rd_addr,
    output logic                                pool_in_valid,
    input  logic                                pool_out_valid,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(IN_W*IN_H/4+1)-1:0]    pooled_cnt,
    output logic                                err
);
    localparam int CNT_W  = $clog2(IN_W*IN_H/4+1);
    localparam int COL_W  = $clog2(IN_W);
    localparam int ROW_W  = $clog2(IN_H+1);
    localparam int PAIR_W = $clog2(IN_W/2+1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PAIR_W-1:0]   pair_q, pair_d;
    logic [CNT_W-1:0]    pooled_q, pooled_d;
    logic [RD_LAT-1:0]   lat_q, lat_d;

    logic feed_go, last_col, count_pulse, pair_full, accept, wdog_hit;

    assign accept      = (state_q == S_IDLE) && start;
    assign feed_go     = (state_q == S_FEED) && !hold;
    assign last_col    = (col_q == COL_W'(IN_W-1));
    assign count_pulse = pool_out_valid && ((state_q == S_FEED) || (state_q == S_WAIT));
    assign pair_full   = (pair_q == PAIR_W'(IN_W/2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_FEED;
            // Only the last column of an odd row closes a row pair.
            S_FEED: if (feed_go && last_col && row_q[0]) state_d = S_WAIT;
            S_WAIT: begin
                if (pair_full)     state_d = (row_q == ROW_W'(IN_H)) ? S_DONE : S_FEED;
                else if (wdog_hit) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en         = feed_go;
        rd_addr       = addr_q;
        pool_in_valid = lat_q[RD_LAT-1];
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        pooled_cnt    = pooled_q;
    end

    always_comb begin
        addr_d   = addr_q;
        col_d    = col_q;
        row_d    = row_q;
        pair_d   = pair_q;
        pooled_d = pooled_q;
        lat_d    = (lat_q << 1) | RD_LAT'(feed_go);
        if (accept) begin
            addr_d   = base_addr;
            col_d    = '0;
            row_d    = '0;
            pair_d   = '0;
            pooled_d = '0;
        end
        if (feed_go) begin
            addr_d = addr_q + ADDR_W'(1);
            if (last_col) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        if (count_pulse) begin
            pair_d   = pair_q + PAIR_W'(1);
            pooled_d = pooled_q + CNT_W'(1);
        end
        // A pulse landing in the release cycle belongs to the next pair.
        if ((state_q == S_WAIT) && pair_full) pair_d = PAIR_W'(count_pulse);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            pair_q   <= '0;
            pooled_q <= '0;
            lat_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pair_q   <= pair_d;
            pooled_q <= pooled_d;
            lat_q    <= lat_d;
        end
    end

`ifdef POOL_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC+1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;

    assign wdog_hit = (state_q == S_WAIT) && !pair_full && (wdog_q == WD_W'(WDOG_CYC-1));
    assign err      = err_q;

    always_comb begin
        wdog_d = (state_q == S_WAIT) ? wdog_q + WD_W'(1) : '0;
        err_d  = err_q;
        if (accept)   err_d = 1'b0;
        if (wdog_hit) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_pool_stream_ctrl.sv
// tb/tb_pool_stream_ctrl.sv - directed bench: 4x4/RD_LAT=1 instance and 28x28/RD_LAT=3 instance
// Watchdog scenario is compiled only when POOL_WDOG_EN is defined.
module tb_pool_stream_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // small instance: 4x4, RD_LAT=1, WDOG_CYC=16
    logic       s_start = 0, s_hold = 0, s_inj = 0, s_mpov = 0, s_withhold = 0;
    logic [9:0] s_base = '0;
    logic       s_pov, s_rd_en, s_piv, s_busy, s_done, s_err;
    logic [9:0] s_rd_addr;
    logic [2:0] s_pcnt;
    assign s_pov = s_mpov | s_inj;

    pool_stream_ctrl #(.IN_W(4), .IN_H(4), .ADDR_W(10), .RD_LAT(1), .WDOG_CYC(16)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .base_addr(s_base), .hold(s_hold),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .pool_in_valid(s_piv), .pool_out_valid(s_pov),
        .busy(s_busy), .done(s_done), .pooled_cnt(s_pcnt), .err(s_err));

    // big instance: 28x28, RD_LAT=3
    logic       b_start = 0, b_hold = 0, b_inj = 0, b_mpov = 0;
    logic [9:0] b_base = '0;
    logic       b_pov, b_rd_en, b_piv, b_busy, b_done, b_err;
    logic [9:0] b_rd_addr;
    logic [7:0] b_pcnt;
    assign b_pov = b_mpov | b_inj;

    pool_stream_ctrl #(.IN_W(28), .IN_H(28), .ADDR_W(10), .RD_LAT(3), .WDOG_CYC(256)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .base_addr(b_base), .hold(b_hold),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .pool_in_valid(b_piv), .pool_out_valid(b_pov),
        .busy(b_busy), .done(b_done), .pooled_cnt(b_pcnt), .err(b_err));

    // Pool stage models: after each 2*IN_W inputs, wait 3 cycles then emit IN_W/2 pulses.
    int sm_cnt = 0, sm_dly = 0, sm_pend = 0, sm_pair = 0;
    always @(negedge clk) begin
        if (rst) begin
            sm_cnt = 0; sm_dly = 0; sm_pend = 0; s_mpov = 0;
        end else begin
            s_mpov = 0;
            if (sm_dly > 0) sm_dly--;
            else if (sm_pend > 0) begin s_mpov = 1; sm_pend--; end
            if (s_piv) begin
                sm_cnt++;
                if (sm_cnt == 8) begin
                    sm_cnt = 0;
                    if (!(s_withhold && sm_pair == 1)) begin sm_dly = 3; sm_pend = 2; end
                    sm_pair++;
                end
            end
        end
    end

    int bm_cnt = 0, bm_dly = 0, bm_pend = 0;
    always @(negedge clk) begin
        if (rst) begin
            bm_cnt = 0; bm_dly = 0; bm_pend = 0; b_mpov = 0;
        end else begin
            b_mpov = 0;
            if (bm_dly > 0) bm_dly--;
            else if (bm_pend > 0) begin b_mpov = 1; bm_pend--; end
            if (b_piv) begin
                bm_cnt++;
                if (bm_cnt == 56) begin bm_cnt = 0; bm_dly = 3; bm_pend = 14; end
            end
        end
    end

    int addr_log[0:63];
    int cyc_log[0:63];

    // Runs one small map; optional hold of hold_len cycles when base+hold_at is about to be read.
    task automatic run_small(input logic [9:0] base, input int hold_at, input int hold_len,
                             output int n_rd, output int done_n, output int pin_bad,
                             output int hold_bad, output int last_rd_c, output int done_c);
        int  hleft;
        int  post;
        bit  held;
        logic prev_rd;
        logic [9:0] hold_addr;
        hold_addr = base + 10'(hold_at);
        n_rd = 0; done_n = 0; pin_bad = 0; hold_bad = 0; last_rd_c = -1; done_c = -1;
        hleft = 0; post = 0; held = 0; prev_rd = 0;
        @(negedge clk); s_base = base; s_start = 1;
        @(negedge clk); s_start = 0;
        for (int c = 0; c < 300 && post < 10; c++) begin
            if (hold_at >= 0 && !held && s_rd_en && s_rd_addr == hold_addr) begin
                s_hold = 1; hleft = hold_len; held = 1;
            end
            #1;
            if (s_hold && s_rd_en) hold_bad++;
            if (s_piv !== prev_rd) pin_bad++;
            if (s_rd_en && n_rd < 64) begin addr_log[n_rd] = s_rd_addr; cyc_log[n_rd] = c; n_rd++; last_rd_c = c; end
            if (s_done) begin done_n++; if (done_c < 0) done_c = c; end
            if (done_n > 0) post++;
            prev_rd = s_rd_en;
            @(negedge clk);
            if (hleft > 0) begin hleft--; if (hleft == 0) s_hold = 0; end
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({s_rd_en, s_rd_addr, s_piv, s_busy, s_done, s_pcnt, s_err} !== 18'd0) begin
            n_fail++; $display("FAIL reset_small outputs=%h required=0", {s_rd_en, s_rd_addr, s_piv, s_busy, s_done, s_pcnt, s_err});
        end
        n_tests++;
        if ({b_rd_en, b_rd_addr, b_piv, b_busy, b_done, b_pcnt, b_err} !== 23'd0) begin
            n_fail++; $display("FAIL reset_big outputs=%h required=0", {b_rd_en, b_rd_addr, b_piv, b_busy, b_done, b_pcnt, b_err});
        end
        @(negedge clk); rst = 0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n_rd, done_n, pin_bad, hold_bad, lrc, dc, bad_addr;
        run_small(10'h010, -1, 0, n_rd, done_n, pin_bad, hold_bad, lrc, dc);
        n_tests++;
        if (n_rd !== 16) begin n_fail++; $display("FAIL basic_nreads got=%0d required=16", n_rd); end
        bad_addr = 0;
        for (int i = 0; i < 16 && i < n_rd; i++) begin
            n_tests++;
            if (addr_log[i] !== 16 + i) begin n_fail++; bad_addr++; $display("FAIL basic_addr[%0d] got=%h required=%h", i, addr_log[i], 16 + i); end
        end
        n_tests++;
        if (n_rd >= 9 && !(cyc_log[8] - cyc_log[7] > 1)) begin
            n_fail++; $display("FAIL basic_pause gap=%0d required>1", cyc_log[8] - cyc_log[7]);
        end
        n_tests++;
        if (pin_bad !== 0) begin n_fail++; $display("FAIL basic_pin_lat1 bad_cycles=%0d required=0", pin_bad); end
        n_tests++;
        if (done_n !== 1) begin n_fail++; $display("FAIL basic_done_count got=%0d required=1", done_n); end
        n_tests++;
        if (s_pcnt !== 3'd4) begin n_fail++; $display("FAIL basic_pooled got=%0d required=4", s_pcnt); end
        n_tests++;
        if (s_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b required=0", s_err); end
    endtask

    task automatic test_hold;
        int n_rd, done_n, pin_bad, hold_bad, lrc, dc;
        logic [9:0] exp;
        run_small(10'h3FA, 6, 5, n_rd, done_n, pin_bad, hold_bad, lrc, dc);
        n_tests++;
        if (n_rd !== 16) begin n_fail++; $display("FAIL hold_nreads got=%0d required=16", n_rd); end
        for (int i = 0; i < 16 && i < n_rd; i++) begin
            exp = 10'h3FA + 10'(i);
            n_tests++;
            if (addr_log[i] !== int'(exp)) begin n_fail++; $display("FAIL hold_addr[%0d] got=%h required=%h", i, addr_log[i], exp); end
        end
        n_tests++;
        if (hold_bad !== 0) begin n_fail++; $display("FAIL hold_rd_en_during_hold cycles=%0d required=0", hold_bad); end
        n_tests++;
        if (n_rd >= 7 && cyc_log[6] - cyc_log[5] !== 6) begin
            n_fail++; $display("FAIL hold_gap got=%0d required=6", cyc_log[6] - cyc_log[5]);
        end
        n_tests++;
        if (done_n !== 1 || s_pcnt !== 3'd4) begin
            n_fail++; $display("FAIL hold_done done=%0d pooled=%0d required done=1 pooled=4", done_n, s_pcnt);
        end
    endtask

    task automatic test_busy_start;
        int c;
        @(negedge clk); s_base = 10'h100; s_start = 1;
        @(negedge clk); s_start = 0;
        @(negedge clk);
        @(negedge clk); s_base = 10'h200; s_start = 1;
        @(negedge clk); s_start = 0; #1;
        n_tests++;
        if (s_rd_addr !== 10'h103 || s_busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_start_ignored addr=%h busy=%b required addr=103 busy=1", s_rd_addr, s_busy);
        end
        c = 0;
        while (!s_done && c < 200) begin @(negedge clk); #1; c++; end
        n_tests++;
        if (!s_done) begin n_fail++; $display("FAIL busy_first_done timeout done=%b required=1", s_done); end
        s_base = 10'h300; s_start = 1;
        @(negedge clk); s_start = 0; #1;
        n_tests++;
        if (s_busy !== 1'b0 || s_pcnt !== 3'd4) begin
            n_fail++; $display("FAIL done_cycle_start busy=%b pooled=%0d required busy=0 pooled=4", s_busy, s_pcnt);
        end
        s_base = 10'h040; s_start = 1;
        @(negedge clk); s_start = 0; #1;
        n_tests++;
        if (s_busy !== 1'b1 || s_rd_en !== 1'b1 || s_rd_addr !== 10'h040) begin
            n_fail++; $display("FAIL restart busy=%b rd_en=%b addr=%h required 1 1 040", s_busy, s_rd_en, s_rd_addr);
        end
        c = 0;
        while (!s_done && c < 200) begin @(negedge clk); #1; c++; end
        n_tests++;
        if (!s_done) begin n_fail++; $display("FAIL restart_done timeout done=%b required=1", s_done); end
        @(negedge clk);
        s_inj = 1; repeat (3) @(negedge clk); s_inj = 0; #1;
        n_tests++;
        if (s_pcnt !== 3'd4) begin n_fail++; $display("FAIL stray_after_done pooled=%0d required=4", s_pcnt); end
    endtask

    task automatic test_reset_midmap_latency;
        int c, n_rd, pin_bad, last_addr;
        bit seen_done;
        logic h1, h2, h3;
        @(negedge clk); b_base = 10'h000; b_start = 1;
        @(negedge clk); b_start = 0;
        c = 0;
        while (!(b_rd_en && b_rd_addr == 10'd61) && c < 300) begin @(negedge clk); c++; end
        rst = 1; #1;
        n_tests++;
        if ({b_rd_en, b_rd_addr, b_piv, b_busy, b_done, b_pcnt, b_err} !== 23'd0) begin
            n_fail++; $display("FAIL reset_midmap outputs=%h required=0", {b_rd_en, b_rd_addr, b_piv, b_busy, b_done, b_pcnt, b_err});
        end
        @(negedge clk); @(negedge clk); rst = 0;
        repeat (5) @(negedge clk);
        #1;
        n_tests++;
        if (b_busy !== 1'b0 || b_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL no_resume busy=%b rd_en=%b required 0 0", b_busy, b_rd_en);
        end
        @(negedge clk); b_inj = 1; repeat (3) @(negedge clk); b_inj = 0; #1;
        n_tests++;
        if (b_pcnt !== 8'd0) begin n_fail++; $display("FAIL stray_idle pooled=%0d required=0", b_pcnt); end
        @(negedge clk); b_start = 1;
        @(negedge clk); b_start = 0;
        n_rd = 0; pin_bad = 0; last_addr = -1; seen_done = 0;
        h1 = 0; h2 = 0; h3 = 0;
        for (int k = 0; k < 4000 && !seen_done; k++) begin
            #1;
            if (b_piv !== h3) pin_bad++;
            h3 = h2; h2 = h1; h1 = b_rd_en;
            if (b_rd_en) begin n_rd++; last_addr = b_rd_addr; end
            if (b_done) begin
                seen_done = 1;
                n_tests++;
                if (b_pcnt !== 8'd196) begin n_fail++; $display("FAIL full_map_pooled got=%0d required=196", b_pcnt); end
            end
            @(negedge clk);
        end
        n_tests++;
        if (!seen_done) begin n_fail++; $display("FAIL full_map_done timeout seen=0 required=1"); end
        n_tests++;
        if (n_rd !== 784 || last_addr !== 783) begin
            n_fail++; $display("FAIL full_map_reads n=%0d last=%0d required n=784 last=783", n_rd, last_addr);
        end
        n_tests++;
        if (pin_bad !== 0) begin n_fail++; $display("FAIL pin_lat3 bad_cycles=%0d required=0", pin_bad); end
    endtask

`ifdef POOL_WDOG_EN
    task automatic test_watchdog;
        int n_rd, done_n, pin_bad, hold_bad, lrc, dc;
        s_withhold = 1; sm_pair = 0;
        run_small(10'h000, -1, 0, n_rd, done_n, pin_bad, hold_bad, lrc, dc);
        n_tests++;
        if (s_err !== 1'b1 || s_pcnt !== 3'd2 || done_n !== 1) begin
            n_fail++; $display("FAIL wdog_trip err=%b pooled=%0d done=%0d required 1 2 1", s_err, s_pcnt, done_n);
        end
        n_tests++;
        if (dc - lrc !== 17) begin n_fail++; $display("FAIL wdog_cycles got=%0d required=17", dc - lrc); end
        s_withhold = 0;
        @(negedge clk); s_start = 1;
        @(negedge clk); s_start = 0; #1;
        n_tests++;
        if (s_err !== 1'b0) begin n_fail++; $display("FAIL wdog_clear err=%b required=0", s_err); end
        repeat (60) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_busy_start();
        test_reset_midmap_latency();
`ifdef POOL_WDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
